// File: rtl/arr_arb_pkg.sv
// arr_arb_pkg: shared types and helpers for the array port arbiter.
// MAX_NREQ bounds the number of kernel requesters any build may use;
// owner indices and the round-robin pointer are sized from it.
package arr_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int OWNER_W  = $clog2(MAX_NREQ);

    // Bookkeeping for the single kernel read that can be in flight
    typedef struct packed {
        logic               pending;
        logic [OWNER_W-1:0] owner;
    } rd_track_t;

    // Round-robin pick over a MAX_NREQ-wide request vector. Scanning starts
    // at ptr and wraps modulo MAX_NREQ. Callers that use fewer requesters
    // zero-pad the upper bits, which are then skipped on the way round, so
    // the result equals a scan modulo the real requester count as long as
    // ptr is below that count.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [OWNER_W-1:0]  ptr
    );
        logic [MAX_NREQ-1:0] pick;
        logic                found;
        logic [OWNER_W-1:0]  idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < MAX_NREQ; off++) begin
            idx = ptr + OWNER_W'(off);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arr_rr_picker.sv
// arr_rr_picker: combinational rotate-priority encoder. The first asserted
// request at or after ptr (wrapping) wins; the winner is returned both
// one-hot and as an index.
module arr_rr_picker
    import arr_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NREQ-1:0]    gnt,
    output logic               pick_valid,
    output logic [OWNER_W-1:0] idx
);

    logic [MAX_NREQ-1:0] req_pad;
    logic [MAX_NREQ-1:0] gnt_pad;

    // Widen to the package width, pick, then encode the winner's index
    always_comb begin
        req_pad           = '0;
        req_pad[NREQ-1:0] = req;
        gnt_pad           = rr_pick(req_pad, ptr);
        gnt               = gnt_pad[NREQ-1:0];
        pick_valid        = |gnt_pad;
        idx               = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (gnt_pad[i]) begin
                idx = OWNER_W'(i);
            end
        end
    end

endmodule

// File: rtl/arr_port_arbiter.sv
// arr_port_arbiter: shares one single-port synchronous array (1-cycle read
// latency) between NREQ kernel requesters and the host control port.
// The host (controlArr) always wins; kernels are served round-robin, one
// access per cycle, and each kernel read is returned with a per-requester
// rvalid one cycle after its grant.
// Build option: define ARB_LOCK_EN to add req_lock, which lets the current
// owner keep the grant for a burst while it holds req and req_lock high.
module arr_port_arbiter
    import arr_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]          req_lock,
`endif
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    input  logic                     controlArr,
    input  logic                     controlArrWEnable,
    input  logic [ADDR_W-1:0]        controlArrAddr,
    input  logic [DATA_W-1:0]        controlArrWData,
    output logic [DATA_W-1:0]        controlArrRData,
    output logic                     arrWEnable,
    output logic [ADDR_W-1:0]        arrAddr,
    output logic [DATA_W-1:0]        arrWData,
    input  logic [DATA_W-1:0]        arrRData,
    output logic                     busy
);

    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] scan_ptr;
    logic [NREQ-1:0]    pick_gnt;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;
    logic               kernel_grant;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    rd_track_t          rd_q;
`ifdef ARB_LOCK_EN
    logic               lock_hold;
    logic               owner_locked;
    logic               sel_lock;
`endif

    // Next round-robin start position after requester k
    function automatic logic [OWNER_W-1:0] ptr_after(input logic [OWNER_W-1:0] k);
        if (k == OWNER_W'(NREQ - 1)) begin
            return '0;
        end
        return k + OWNER_W'(1);
    endfunction

    // Choose where the scan starts; a released lock moves past its owner
    always_comb begin
        scan_ptr = rr_ptr;
`ifdef ARB_LOCK_EN
        owner_locked = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_ptr == OWNER_W'(i)) begin
                owner_locked = req[i] & req_lock[i];
            end
        end
        if (lock_hold && !owner_locked) begin
            scan_ptr = ptr_after(rr_ptr);
        end
`endif
    end

    arr_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req        (req),
        .ptr        (scan_ptr),
        .gnt        (pick_gnt),
        .pick_valid (pick_valid),
        .idx        (pick_idx)
    );

    // A kernel only gets the array when the host does not want it
    assign kernel_grant = pick_valid & ~controlArr;
    assign gnt          = (kernel_grant & ~rst) ? pick_gnt : '0;

    // One-hot mux of the winning requester's access fields
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
`ifdef ARB_LOCK_EN
        sel_lock  = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
`ifdef ARB_LOCK_EN
                sel_lock  = req_lock[i];
`endif
            end
        end
    end

    // Drive the memory port: host passthrough, kernel access, or idle
    always_comb begin
        if (controlArr) begin
            arrWEnable = controlArrWEnable;
            arrAddr    = controlArrAddr;
            arrWData   = controlArrWData;
        end else if (kernel_grant && !rst) begin
            arrWEnable = sel_we;
            arrAddr    = sel_addr;
            arrWData   = sel_wdata;
        end else begin
            arrWEnable = 1'b0;
            arrAddr    = 'x;
            arrWData   = 'x;
        end
    end

    assign rdata           = arrRData;
    assign controlArrRData = controlArr ? arrRData : 'x;

    // Flag the owner of the read whose data is on rdata this cycle
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_q.pending && (rd_q.owner == OWNER_W'(i))) begin
                rvalid[i] = 1'b1;
            end
        end
    end

    assign busy = rd_q.pending;

    // Advance the round-robin pointer and record the in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            rd_q      <= '0;
`ifdef ARB_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            if (kernel_grant) begin
`ifdef ARB_LOCK_EN
                rr_ptr    <= sel_lock ? pick_idx : ptr_after(pick_idx);
                lock_hold <= sel_lock;
`else
                rr_ptr    <= ptr_after(pick_idx);
`endif
            end
            rd_q.pending <= kernel_grant & ~sel_we;
            if (kernel_grant && !sel_we) begin
                rd_q.owner <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// tb_arr_port_arbiter: directed scenarios plus randomized traffic for
// arr_port_arbiter, checked against a behavioural model of the arbitration,
// read-return and host-bypass rules. Define ARB_LOCK_EN to also exercise
// the burst-lock option.
module tb_arr_port_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   controlArr;
    logic                   controlArrWEnable;
    logic [ADDR_W-1:0]      controlArrAddr;
    logic [DATA_W-1:0]      controlArrWData;
    logic [DATA_W-1:0]      controlArrRData;
    logic                   arrWEnable;
    logic [ADDR_W-1:0]      arrAddr;
    logic [DATA_W-1:0]      arrWData;
    logic [DATA_W-1:0]      arrRData;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] shadow [DEPTH];
    int                last_owner;
    bit                last_locked;
    bit                pend;
    int                pend_owner;
    logic [DATA_W-1:0] pend_data;
    bit                host_pend;
    logic [DATA_W-1:0] host_data;

    // Array model driven by the DUT
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;
    logic              mem_init;

    arr_port_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
`ifdef ARB_LOCK_EN
        .req_lock          (req_lock),
`endif
        .gnt               (gnt),
        .rvalid            (rvalid),
        .rdata             (rdata),
        .controlArr        (controlArr),
        .controlArrWEnable (controlArrWEnable),
        .controlArrAddr    (controlArrAddr),
        .controlArrWData   (controlArrWData),
        .controlArrRData   (controlArrRData),
        .arrWEnable        (arrWEnable),
        .arrAddr           (arrAddr),
        .arrWData          (arrWData),
        .arrRData          (arrRData),
        .busy              (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single-port array: writes land, reads capture the address on non-write cycles
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_q <= '0;
        end else if (arrWEnable) begin
            mem[arrAddr] <= arrWData;
        end else begin
            mem_q <= mem[arrAddr];
        end
    end
    assign arrRData = mem_q;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, check the DUT against the model, then advance the model
    task automatic applyStimulus(
        input logic [NREQ-1:0]        r,
        input logic [NREQ-1:0]        we,
        input logic [NREQ*ADDR_W-1:0] a,
        input logic [NREQ*DATA_W-1:0] d,
        input logic                   c,
        input logic                   cwe,
        input logic [ADDR_W-1:0]      ca,
        input logic [DATA_W-1:0]      cd,
        input logic [NREQ-1:0]        lk
    );
        int              k;
        int              start;
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_rvalid;
        logic [ADDR_W-1:0] ka;
        logic [DATA_W-1:0] kd;
        @(negedge clk);
        req               = r;
        req_we            = we;
        req_addr          = a;
        req_wdata         = d;
        controlArr        = c;
        controlArrWEnable = cwe;
        controlArrAddr    = ca;
        controlArrWData   = cd;
`ifdef ARB_LOCK_EN
        req_lock          = lk;
`endif
        #1;
        k       = -1;
        exp_gnt = '0;
        if (!c) begin
            if (last_locked && last_owner >= 0 && r[last_owner] && lk[last_owner]) begin
                k = last_owner;
            end else begin
                start = (last_owner < 0) ? 0 : (last_owner + 1) % NREQ;
                for (int off = 0; off < NREQ; off++) begin
                    if (k < 0 && r[(start + off) % NREQ]) k = (start + off) % NREQ;
                end
            end
            if (k >= 0) exp_gnt[k] = 1'b1;
        end
        exp_rvalid = '0;
        if (pend) exp_rvalid[pend_owner] = 1'b1;
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("rvalid", 32'(rvalid), 32'(exp_rvalid));
        checkOutput("busy", 32'(busy), 32'(pend));
        if (pend) checkOutput("rdata", 32'(rdata), 32'(pend_data));
        if (c && host_pend) checkOutput("host_rdata", 32'(controlArrRData), 32'(host_data));
        if (k >= 0) begin
            ka = a[k*ADDR_W +: ADDR_W];
            kd = d[k*DATA_W +: DATA_W];
        end else begin
            ka = '0;
            kd = '0;
        end
        if (c) begin
            checkOutput("host_we", 32'(arrWEnable), 32'(cwe));
            checkOutput("host_addr", 32'(arrAddr), 32'(ca));
            if (cwe) checkOutput("host_wdata", 32'(arrWData), 32'(cd));
        end else if (k >= 0) begin
            checkOutput("arr_we", 32'(arrWEnable), 32'(we[k]));
            checkOutput("arr_addr", 32'(arrAddr), 32'(ka));
            if (we[k]) checkOutput("arr_wdata", 32'(arrWData), 32'(kd));
        end else begin
            checkOutput("idle_we", 32'(arrWEnable), 32'(0));
        end
        if (c) begin
            pend = 1'b0;
            if (cwe) begin
                shadow[ca] = cd;
                host_pend  = 1'b0;
            end else begin
                host_pend = 1'b1;
                host_data = shadow[ca];
            end
        end else begin
            host_pend = 1'b0;
            if (k >= 0) begin
                last_owner  = k;
                last_locked = lk[k];
                if (we[k]) begin
                    shadow[ka] = kd;
                    pend       = 1'b0;
                end else begin
                    pend       = 1'b1;
                    pend_owner = k;
                    pend_data  = shadow[ka];
                end
            end else begin
                pend = 1'b0;
            end
        end
    endtask

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by random traffic
    initial begin
        logic [NREQ-1:0]        r_r, r_we, r_lk;
        logic [NREQ*ADDR_W-1:0] r_a;
        logic [NREQ*DATA_W-1:0] r_d;
        logic                   r_c, r_cwe;
        logic [ADDR_W-1:0]      r_ca;
        logic [DATA_W-1:0]      r_cd;

        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        last_owner  = -1;
        last_locked = 1'b0;
        pend        = 1'b0;
        pend_owner  = 0;
        pend_data   = '0;
        host_pend   = 1'b0;
        host_data   = '0;

        rst               = 1'b1;
        mem_init          = 1'b1;
        req               = '1;
        req_we            = '0;
        req_addr          = '0;
        req_wdata         = '0;
        controlArr        = 1'b0;
        controlArrWEnable = 1'b0;
        controlArrAddr    = '0;
        controlArrWData   = '0;
`ifdef ARB_LOCK_EN
        req_lock          = '0;
`endif
        #3;
        checkOutput("rst_gnt", 32'(gnt), 32'(0));
        checkOutput("rst_rvalid", 32'(rvalid), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_gnt_held", 32'(gnt), 32'(0));
        mem_init = 1'b0;
        req      = '0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] kernel writes, round-robin");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(3'b011, 3'b011, {3'd0, 3'd1, 3'd0}, {8'd0, 8'd0, 8'd1},
                          1'b0, 1'b0, '0, '0, '0);
            checkOutput("plan_wr_gnt", 32'(gnt), (n == 1) ? 32'h2 : 32'h1);
        end

        $display("[TB] back-to-back kernel reads");
        applyStimulus(3'b001, 3'b000, {3'd0, 3'd1, 3'd0}, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("plan_mem0", 32'(mem[0]), 32'h1);
        checkOutput("plan_mem1", 32'(mem[1]), 32'h0);
        checkOutput("plan_rd0_gnt", 32'(gnt), 32'h1);
        applyStimulus(3'b010, 3'b000, {3'd0, 3'd1, 3'd0}, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("plan_rd1_gnt", 32'(gnt), 32'h2);
        checkOutput("plan_rv0", 32'(rvalid), 32'h1);
        checkOutput("plan_rd0_data", 32'(rdata), 32'h1);
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("plan_rv1", 32'(rvalid), 32'h2);
        checkOutput("plan_rd1_data", 32'(rdata), 32'h0);

        $display("[TB] host takeover");
        applyStimulus(3'b011, 3'b000, '0, '0, 1'b1, 1'b1, 3'd1, 8'd1, '0);
        checkOutput("plan_host_gnt", 32'(gnt), 32'h0);
        applyStimulus(3'b011, 3'b000, '0, '0, 1'b1, 1'b0, 3'd1, '0, '0);
        checkOutput("plan_host_gnt2", 32'(gnt), 32'h0);
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 3'd0, '0, '0);
        checkOutput("plan_host_rdata", 32'(controlArrRData), 32'h1);
        applyStimulus(3'b011, 3'b000, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("plan_ptr_kept", 32'(gnt), 32'h1);

        $display("[TB] kernel read then host takeover");
        applyStimulus(3'b001, 3'b000, {3'd0, 3'd0, 3'd1}, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 3'd0, '0, '0);
        checkOutput("plan_take_rv", 32'(rvalid), 32'h1);
        checkOutput("plan_take_data", 32'(rdata), 32'h1);
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] async reset with a read in flight");
        applyStimulus(3'b010, 3'b000, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("plan_rst_rd_gnt", 32'(gnt), 32'h2);
        @(posedge clk);
        #2;
        checkOutput("plan_busy_inflight", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("plan_rst_busy", 32'(busy), 32'h0);
        checkOutput("plan_rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("plan_rst_gnt", 32'(gnt), 32'h0);
        req         = '0;
        last_owner  = -1;
        last_locked = 1'b0;
        pend        = 1'b0;
        host_pend   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);

`ifdef ARB_LOCK_EN
        $display("[TB] burst lock");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(3'b011, 3'b011, '0, '0, 1'b0, 1'b0, '0, '0, 3'b001);
            checkOutput("plan_lock_gnt", 32'(gnt), 32'h1);
        end
        applyStimulus(3'b011, 3'b011, '0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
        checkOutput("plan_unlock_gnt", 32'(gnt), 32'h2);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            r_r   = NREQ'($urandom);
            r_we  = NREQ'($urandom);
            r_a   = (NREQ*ADDR_W)'($urandom);
            r_d   = (NREQ*DATA_W)'({$urandom, $urandom});
            r_c   = ($urandom_range(0, 4) == 0);
            r_cwe = 1'($urandom);
            r_ca  = ADDR_W'($urandom);
            r_cd  = DATA_W'($urandom);
            r_lk  = '0;
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 2) == 0) r_lk = NREQ'($urandom);
`endif
            applyStimulus(r_r, r_we, r_a, r_d, r_c, r_cwe, r_ca, r_cd, r_lk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arr_port_arbiter.md
Name: arr_port_arbiter

Overview:
- Shares one single-port synchronous array (arr_* instance: 1-cycle read latency, read address captured only on non-write cycles) between NREQ synthesized kernel FSMs and the host control port.
- Host `controlArr` has absolute priority. Kernels are served round-robin, one access per cycle.
- Tracks the owner of each in-flight read and returns a per-requester read-valid.
- Sits between the kernel `main` instances and the `arr_*` memory, replacing the single-master `controlArr` mux.

Parameters:
- NREQ, 2, number of kernel requesters (2..8).
- ADDR_W, 1, array address width.
- DATA_W, 1, array data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-kernel access request; level, held until granted.
- req_we  input  NREQ  per-kernel write enable (1 = write, 0 = read).
- req_addr  input  NREQ*ADDR_W  per-kernel address, packed; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NREQ*DATA_W  per-kernel write data, packed the same way.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as the access.
- rvalid  output  NREQ  one-hot; rdata holds read data for that requester this cycle.
- rdata  output  DATA_W  read data, driven from arrRData.
- controlArr  input  1  host owns the array.
- controlArrWEnable  input  1  host write enable.
- controlArrAddr  input  ADDR_W  host address.
- controlArrWData  input  DATA_W  host write data.
- controlArrRData  output  DATA_W  host read data: arrRData while controlArr, else 'x.
- arrWEnable  output  1  to memory.
- arrAddr  output  ADDR_W  to memory.
- arrWData  output  DATA_W  to memory.
- arrRData  input  DATA_W  from memory.
- busy  output  1  registered; 1 while any kernel read is awaiting return.

Behaviour:
- Reset values:
  - rr_ptr = 0; rd_pending = 0; rd_owner = 0; busy = 0.
  - rvalid = 0 in the reset cycle and the first cycle after it.
  - gnt = 0 while rst is high.
- Arbitration (combinational):
  - If controlArr = 1: gnt = 0, and the memory ports pass the controlArr* signals straight through.
  - Otherwise, grant the first i with req[i] = 1, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - No requests: gnt = 0, arrWEnable = 0, arrAddr = 'x, arrWData = 'x.
- Pointer update: on a cycle with a kernel grant to requester k, rr_ptr <= (k+1) mod NREQ. Otherwise rr_ptr holds.
- Memory drive on a grant to k: arrWEnable = req_we[k], arrAddr = req_addr slice k, arrWData = req_wdata slice k.
- Read tracking:
  - A granted read (req_we = 0) sets rd_pending <= 1 and rd_owner <= k at the posedge. Any other cycle clears rd_pending.
  - rvalid[rd_owner] = rd_pending, exactly one cycle after the grant. This gives back-to-back reads at full rate.
  - busy = rd_pending.
- Host takeover with a read in flight: the pending kernel read still returns rvalid and the correct data the next cycle, because the memory has already latched the address. Host reads return data on controlArrRData one cycle after issue.
- A write grant produces no rvalid.
- A requester that drops req before being granted is simply skipped; there is no error.
- Asynchronous reset mid-read clears rd_pending immediately; no rvalid is produced for that read.

Optional Feature:
- ARB_LOCK_EN adds input `req_lock` [NREQ].
- With the macro defined: while the current owner k keeps req[k] and req_lock[k] high, rr_ptr stays at k and k keeps the grant (burst access). Lock is ignored if controlArr is high. The lock releases when req_lock[k] falls.
- Without the macro: the port is absent and pure round-robin applies.

Decomposition:
- Package arr_arb_pkg holds:
  - MAX_NREQ = 8.
  - The rd_track_t struct {pending, owner}.
  - Function rr_pick(req, ptr), returning a one-hot grant.
- One natural sub-module, arr_rr_picker: a combinational rotate-priority-encode. It is instantiated once.

Test Plan:
- After reset, NREQ=2, req=2'b11, both writes, addr 0/1, data 1/0 → gnt 01,10,01 on consecutive cycles; memory ends with mem[0]=1, mem[1]=0.
- Requester 0 reads addr 0 (=1) and requester 1 reads addr 1 (=0) back-to-back → rvalid=01 with rdata=1, then rvalid=10 with rdata=0, each one cycle after its grant.
- controlArr=1 while req=11 → gnt=00; a host write of 1 to addr 1 lands. A host read the next cycle gives controlArrRData=1 one cycle later; rr_ptr is unchanged.
- Kernel read granted in cycle N, controlArr rises in cycle N+1 → rvalid for the kernel in cycle N+1 with the correct data.
- Assert rst asynchronously between a read grant and its return → rvalid stays 00, busy drops to 0 without waiting for clk.
- With ARB_LOCK_EN: req=11, req_lock[0]=1 for 3 cycles → gnt=01 for 3 cycles, then 10 after the lock drops.
